// File: rtl/jtsdram_bank_rw.sv
// Per-bank SDRAM test channel: sweeps an address range, optionally writes an
// address-derived pattern, reads it back and tracks mismatches.
module jtsdram_bank_rw #(
    parameter int          AW     = 22,
    parameter int          DW     = 16,
    parameter int          EW     = 8,
    parameter logic [31:0] SEED   = 32'h5A3C,
    parameter int          GAP    = 4,
    parameter int          VBONLY = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          LVBL,
    input  logic          start,
    input  logic          mode,
    input  logic          slow,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] len,
    output logic [AW-1:0] addr,
    output logic          rd,
    output logic          wr,
    output logic [DW-1:0] din,
    output logic [1:0]    din_m,
    input  logic          ack,
    input  logic          rdy,
    input  logic [31:0]   data_read,
    output logic          busy,
    output logic          done,
    output logic          bad,
    output logic [EW-1:0] err_cnt,
    output logic [AW-1:0] fail_addr
);

    typedef enum logic [2:0] {IDLE, WAIT_VB, REQ, RESP, GAP_W, FIN} state_t;

    state_t        st;
    logic [AW-1:0] cnt;
    logic          mode_r;
    logic          slow_r;
    logic          wph;       // current address is in its write phase
    logic [15:0]   gap_cnt;
    logic          unused_rd_hi;

    assign din_m        = 2'b00;
    assign unused_rd_hi = ^data_read;

    // Reference pattern; the address is zero-extended when narrower than DW.
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input logic m);
        logic [AW+DW-1:0] ext;
        ext = {{DW{1'b0}}, a};
        return ext[DW-1:0] ^ SEED[DW-1:0] ^ {DW{m}};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            addr      <= '0;
            din       <= '0;
            err_cnt   <= '0;
            fail_addr <= '0;
            rd        <= 1'b0;
            wr        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bad       <= 1'b0;
            cnt       <= '0;
            mode_r    <= 1'b0;
            slow_r    <= 1'b0;
            wph       <= 1'b0;
            gap_cnt   <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (start) begin
                        bad       <= 1'b0;
                        err_cnt   <= '0;
                        fail_addr <= '0;
                        done      <= 1'b0;
                        addr      <= base;
                        cnt       <= len;
                        busy      <= 1'b1;
                        mode_r    <= mode;
                        slow_r    <= slow;
                        wph       <= mode;
                        st        <= WAIT_VB;
                    end
                end
                WAIT_VB: begin
                    if (!(VBONLY != 0 && LVBL)) begin
                        st <= REQ;
                        if (wph) begin
                            wr  <= 1'b1;
                            din <= pat(addr, mode_r);
                        end else begin
                            rd  <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (ack) begin
                        rd <= 1'b0;
                        wr <= 1'b0;
                        st <= RESP;
                    end
                end
                RESP: begin
                    if (rdy) begin
                        if (wph) begin
                            wph <= 1'b0;
                            st  <= WAIT_VB;
                        end else begin
                            if (data_read[DW-1:0] != pat(addr, mode_r)) begin
                                bad <= 1'b1;
                                if (err_cnt != {EW{1'b1}}) err_cnt <= err_cnt + 1'b1;
                                if (err_cnt == '0) fail_addr <= addr;
                            end
                            addr <= addr + 1'b1;
                            // len==0 loads cnt=0, which wraps and covers 2^AW addresses
                            cnt  <= cnt - 1'b1;
                            wph  <= mode_r;
                            if (cnt == {{(AW-1){1'b0}}, 1'b1}) begin
                                st <= FIN;
                            end else if (slow_r && GAP > 0) begin
                                gap_cnt <= 16'(GAP);
                                st      <= GAP_W;
                            end else begin
                                st <= WAIT_VB;
                            end
                        end
                    end
                end
                GAP_W: begin
                    if (gap_cnt <= 16'd1) st <= WAIT_VB;
                    else gap_cnt <= gap_cnt - 16'd1;
                end
                FIN: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    st   <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule
